// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or two's-complement.
// Latency: start accepted at edge k, product valid with a one-cycle done pulse after edge k+WIDTH.
// No backpressure: start is sampled only in IDLE/DONE and ignored while busy.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand_mag;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     hi;
  logic               neg;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mag_prod;

  // Operand magnitudes and one shift-add step; the most-negative value maps to
  // 2^(WIDTH-1), which is still exact when treated as unsigned.
  always_comb begin
    a_mag    = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    b_mag    = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    sum      = lo[0] ? (hi + {1'b0, mcand_mag}) : hi;
    // {sum, lo} shifted right by one, dropping the carry bit that is always 0 at the end
    mag_prod = {sum, lo[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, accept decode and status outputs
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_iter = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, write product on the final iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mcand_mag <= '0;
      lo        <= '0;
      hi        <= '0;
      neg       <= 1'b0;
      product   <= '0;
    end else if (accept) begin
      mcand_mag <= a_mag;
      lo        <= b_mag;
      hi        <= '0;
      neg       <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      cnt       <= '0;
    end else if (state == S_RUN) begin
      hi  <= {1'b0, sum[WIDTH:1]};
      lo  <= {sum[0], lo[WIDTH-1:1]};
      cnt <= cnt + CNT_W'(1);
      if (last_iter) begin
        product <= neg ? -mag_prod : mag_prod;
      end
    end
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier: WIDTH x WIDTH operands, 2*WIDTH-bit product.
- Control FSM, iteration counter and accumulate/shift datapath are combined in one block, with a start/done handshake.
- Supports unsigned and signed (two's-complement) modes, selected per operation.
- Used as the multiply unit behind the ALU; runs one iteration per clock.

Parameters:
- WIDTH, 32, operand width in bits; legal values are WIDTH >= 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = operands are two's-complement; 0 = unsigned; sampled with start.
- multiplicand  input  WIDTH  operand A; sampled with start.
- multiplier  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while iterating (state RUN).
- done  output  1  one-cycle pulse when the product becomes valid.
- product  output  2*WIDTH  result register; holds the last result until the next result is written.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, product=0, counter=0, internal registers=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> accept, go to RUN. Otherwise stay.
  - RUN: counter increments each cycle. At counter==WIDTH-1 the final iteration executes, then go to DONE.
  - DONE: done=1. With start=1 -> accept, go to RUN (back-to-back). Otherwise go to IDLE.
- Accept edge:
  - Latch mcand_mag and mplier_mag: the magnitudes if signed_mode=1 and MSB=1, else the raw values.
  - Latch neg = signed_mode & (A[MSB] ^ B[MSB]).
  - Set hi=0 (WIDTH+1 bits including carry), lo=mplier_mag, counter=0.
- Iteration, one per RUN cycle:
  - If lo[0]=1, sum = hi + mcand_mag; else sum = hi.
  - Shift {sum, lo} right by one.
  - After WIDTH iterations, {hi[WIDTH-1:0], lo} = mcand_mag * mplier_mag exactly, with no overflow.
- Product write: on the RUN->DONE edge, product = neg ? two's-complement negation of the magnitude product : the magnitude product.
  - product is written on that edge only.
- Latency: start sampled at edge k.
  - busy=1 after edges k .. k+WIDTH-1.
  - done=1 and product valid after edge k+WIDTH, for exactly one cycle.
  - Back-to-back throughput: one result per WIDTH+1 cycles.
- start while in RUN is ignored; no queueing, no restart.
- Operand and signed_mode changes after the accept edge have no effect.
- Boundary conditions:
  - Signed most-negative operand -2^(WIDTH-1): its WIDTH-bit magnitude 2^(WIDTH-1) is used unsigned, which is correct.
  - (-2^(W-1)) * (-2^(W-1)) = 2^(2W-2), which fits the signed product.
  - Zero operand: product 0 with neg ignored; negating 0 yields 0.
  - start held high continuously: results every WIDTH+1 cycles, with DONE visited each time.
- rst_n asserted mid-RUN: immediate abort, all registers at reset values, product cleared.
  - The first start after release behaves as from IDLE.
- busy and done are never high together. done is never high for two consecutive cycles without an intervening accept.

Test Plan:
- Reset: drive rst_n=0 with random inputs -> busy=0, done=0, product=0. Release with start=0 for 5 cycles -> outputs stay 0.
- Unsigned, WIDTH=8: A=200, B=250, signed_mode=0, start at edge k.
  - busy=1 for edges k..k+7; done=1 after edge k+8 only; product=16'hC350 (50000), held after done drops.
  - Also check A=255, B=255 -> 16'hFE01.
- Signed, WIDTH=8:
  - A=8'hF9 (-7), B=9 -> 16'hFFC1 (-63).
  - A=8'h80, B=8'h80 -> 16'h4000.
  - A=8'h80, B=1 -> 16'hFF80.
  - A=0, B=8'hFF -> 16'h0000.
  - Same bit patterns with signed_mode=0: 8'h80 * 8'h80 -> 16'h4000; 8'hF9 * 9 -> 16'h08C1.
- Handshake: A=3, B=5 accepted.
  - Pulse start and change A/B/signed_mode at edges k+2 and k+4 -> result still 15, done still after edge k+8.
  - Hold start=1 in DONE with A=6, B=7 -> busy reasserts, next done after edge k+17 with product 42.
- Reset mid-operation: accept A=100, B=100, assert rst_n=0 at edge k+4 -> outputs cleared immediately.
  - Release and accept A=2, B=3 -> product 6 and done exactly 8 edges after accept.
- WIDTH=32 default: 32'hFFFFFFFF * 32'hFFFFFFFF unsigned -> 64'hFFFFFFFE00000001, done after 32 edges.
  - Signed -1 * -1 -> 64'h1.
  - 1000 random operand pairs in each mode match the reference model.
